// File: rtl/l2_rr_arbiter_pkg.sv
// Shared types for the L2 line-port arbiter: line/address widths and the
// two-way requester select used by the arbiter and its round-robin picker.
package l2_rr_arbiter_pkg;

    localparam int unsigned LC3B_LINE_W = 128;
    localparam int unsigned LC3B_ADDR_W = 16;

    typedef logic [LC3B_LINE_W-1:0] lc3b_pmem_line;
    typedef logic [LC3B_ADDR_W-1:0] lc3b_pmem_addr;

    typedef enum logic {
        ARB_A = 1'b0,
        ARB_B = 1'b1
    } lc3b_arb_sel;

    function automatic lc3b_arb_sel arb_other(input lc3b_arb_sel s);
        return (s == ARB_A) ? ARB_B : ARB_A;
    endfunction

endpackage

// File: rtl/l2_rr_arbiter_pick.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// under contention the port that was not served last wins.
module rr_pick2
    import l2_rr_arbiter_pkg::*;
(
    input  logic        req_a,
    input  logic        req_b,
    input  lc3b_arb_sel last,
    output logic        grant_valid,
    output lc3b_arb_sel grant_sel
);

    always_comb begin
        grant_valid = req_a | req_b;
        grant_sel   = ARB_A;
        if (req_a && req_b) begin
            grant_sel = arb_other(last);
        end else if (req_b) begin
            grant_sel = ARB_B;
        end
    end

endmodule

// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter sharing the single L2 line port between icache (A)
// and dcache (B); one transaction at a time, request latched at grant.
module l2_rr_arbiter
    import l2_rr_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W  = LC3B_LINE_W,
    parameter int unsigned ADDR_W  = LC3B_ADDR_W,
    parameter bit          A_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_a,
    input  logic              write_a,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [LINE_W-1:0] wdata_a,
    output logic              resp_a,
    output logic [LINE_W-1:0] rdata_a,
    input  logic              read_b,
    input  logic              write_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [LINE_W-1:0] wdata_b,
    output logic              resp_b,
    output logic [LINE_W-1:0] rdata_b,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [LINE_W-1:0] l2_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // After reset the opposite port counts as last served, so A_FIRST's port wins first.
    localparam lc3b_arb_sel LAST_RST = A_FIRST ? ARB_B : ARB_A;

    state_t            state_q, state_d;
    lc3b_arb_sel       last_q, sel_q, pick_sel;
    logic              pick_valid;
    logic              req_a, req_b;
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q, rdata_a_q, rdata_b_q;

    assign req_a = read_a | write_a;
    assign req_b = read_b | write_b;

    rr_pick2 u_pick (
        .req_a       (req_a),
        .req_b       (req_b),
        .last        (last_q),
        .grant_valid (pick_valid),
        .grant_sel   (pick_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ACCESS;
            ACCESS:  if (l2_resp)    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant latch, read-data capture and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q     <= LAST_RST;
            sel_q      <= ARB_A;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            if (state_q == IDLE && pick_valid) begin
                sel_q <= pick_sel;
                if (pick_sel == ARB_A) begin
                    op_write_q <= write_a;
                    addr_q     <= address_a;
                    wdata_q    <= wdata_a;
                end else begin
                    op_write_q <= write_b;
                    addr_q     <= address_b;
                    wdata_q    <= wdata_b;
                end
            end
            if (state_q == ACCESS && l2_resp) begin
                if (sel_q == ARB_A) begin
                    rdata_a_q <= l2_rdata;
                end else begin
                    rdata_b_q <= l2_rdata;
                end
            end
            if (state_q == RESP) begin
                last_q <= sel_q;
            end
        end
    end

    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        resp_a   = 1'b0;
        resp_b   = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            ACCESS: begin
                l2_read  = ~op_write_q;
                l2_write = op_write_q;
            end
            RESP: begin
                resp_a = (sel_q == ARB_A);
                resp_b = (sel_q == ARB_B);
            end
            default: ;
        endcase
    end

    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;
    assign rdata_a    = rdata_a_q;
    assign rdata_b    = rdata_b_q;

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Self-checking bench for l2_rr_arbiter: directed scenarios plus random
// two-client traffic against a transaction-level reference model.
module tb_l2_rr_arbiter;

    localparam int LW = 128;
    localparam int AW = 16;
    localparam bit A_FIRST_TB = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd [2];
    logic          wr [2];
    logic [AW-1:0] addr [2];
    logic [LW-1:0] wd [2];
    logic          resp_a, resp_b, l2_read, l2_write, l2_resp, busy;
    logic [LW-1:0] rdata_a, rdata_b, l2_wdata, l2_rdata;
    logic [AW-1:0] l2_address;

    always #5 clk = ~clk;

    l2_rr_arbiter #(.LINE_W(LW), .ADDR_W(AW), .A_FIRST(A_FIRST_TB)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_a(rd[0]), .write_a(wr[0]), .address_a(addr[0]), .wdata_a(wd[0]),
        .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(rd[1]), .write_b(wr[1]), .address_b(addr[1]), .wdata_b(wd[1]),
        .resp_b(resp_b), .rdata_b(rdata_b),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_resp(l2_resp), .l2_rdata(l2_rdata), .busy(busy)
    );

    int vec = 0;
    int miss = 0;

    // Reference model: phase 0 = free, 1 = line access outstanding, 2 = completion cycle.
    int            ph = 0;
    int            cur = 0;
    int            last = 1;
    logic          cur_w = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [LW-1:0] exp_wd = '0;
    logic [LW-1:0] exp_rd [2];
    int            order [$];
    int            rcnt [2];

    // Client and L2 responder knobs.
    int            mode [2];
    logic          dropped [2];
    bit            scramble = 1'b0;
    int            fix_d = -1;
    int            fix_w = -1;
    bit            fix_data_en = 1'b0;
    logic [LW-1:0] fix_data = '0;
    logic          l2_pend = 1'b0;
    logic          l2_served = 1'b0;
    int            l2_wait_cnt = 0;
    int            l2_hold = 0;

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [31:0] r;
        r = $urandom();
        return r[AW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int p);
        if ($urandom_range(0, 1) == 1) wr[p] = 1'b1;
        else rd[p] = 1'b1;
        addr[p] = rand_addr();
        wd[p]   = rand_line();
    endtask

    task automatic tick();
        int   nph;
        logic qa, qb;
        nph = ph;
        qa  = rd[0] | wr[0];
        qb  = rd[1] | wr[1];
        assert (!(rd[0] && wr[0]) && !(rd[1] && wr[1])) else begin
            miss++;
            $error("FAIL stim_rw_both: read&write both high observed 1 expected 0");
        end
        if (!rst_n) begin
            nph = 0;
            last = A_FIRST_TB ? 1 : 0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            exp_addr = '0;
            exp_wd = '0;
            cur_w = 1'b0;
        end else if (ph == 0) begin
            if (qa || qb) begin
                cur = (qa && qb) ? 1 - last : (qa ? 0 : 1);
                cur_w = wr[cur];
                exp_addr = addr[cur];
                exp_wd = wd[cur];
                order.push_back(cur);
                nph = 1;
            end
        end else if (ph == 1) begin
            if (l2_resp) begin
                exp_rd[cur] = l2_rdata;
                nph = 2;
            end
        end else begin
            last = cur;
            nph = 0;
        end

        @(posedge clk);
        #1;
        ph = nph;

        chk("busy", busy, ph != 0);
        chk("l2_read", l2_read, ph == 1 && !cur_w);
        chk("l2_write", l2_write, ph == 1 && cur_w);
        chk("resp_a", resp_a, ph == 2 && cur == 0);
        chk("resp_b", resp_b, ph == 2 && cur == 1);
        chk("rdata_a", rdata_a, exp_rd[0]);
        chk("rdata_b", rdata_b, exp_rd[1]);
        chk("l2_address", l2_address, exp_addr);
        chk("l2_wdata", l2_wdata, exp_wd);

        rcnt[0] += int'(resp_a);
        rcnt[1] += int'(resp_b);

        // Clients drop in the completion cycle and may re-request from the next one.
        for (int p = 0; p < 2; p++) begin
            dropped[p] = 1'b0;
            if (ph == 2 && cur == p) begin
                rd[p] = 1'b0;
                wr[p] = 1'b0;
                dropped[p] = 1'b1;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (rst_n && !rd[p] && !wr[p] && !dropped[p]) begin
                if (mode[p] == 1 || (mode[p] == 2 && $urandom_range(0, 2) == 0)) new_req(p);
            end
        end
        if (ph == 1 && scramble) begin
            addr[cur] = rand_addr();
            wd[cur]   = rand_line();
        end

        if (ph != 1) l2_served = 1'b0;
        if (ph == 1 && !l2_pend && !l2_served) begin
            l2_pend = 1'b1;
            l2_wait_cnt = (fix_d >= 0) ? fix_d : int'($urandom_range(0, 3));
        end
        if (l2_pend) begin
            if (l2_wait_cnt == 0) begin
                l2_resp   = 1'b1;
                l2_rdata  = fix_data_en ? fix_data : rand_line();
                l2_hold   = ((fix_w > 0) ? fix_w : int'($urandom_range(1, 3))) - 1;
                l2_pend   = 1'b0;
                l2_served = 1'b1;
            end else begin
                l2_resp = 1'b0;
                l2_wait_cnt--;
            end
        end else if (l2_hold > 0) begin
            l2_resp = 1'b1;
            l2_hold--;
        end else begin
            l2_resp = 1'b0;
        end
    endtask

    task automatic clear_stim();
        for (int p = 0; p < 2; p++) begin
            rd[p] = 1'b0;
            wr[p] = 1'b0;
            mode[p] = 0;
            dropped[p] = 1'b0;
            rcnt[p] = 0;
        end
        l2_resp = 1'b0;
        l2_pend = 1'b0;
        l2_served = 1'b0;
        l2_hold = 0;
        l2_wait_cnt = 0;
        order.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_stim();
        tick();
        rst_n = 1'b1;
        rcnt[0] = 0;
        rcnt[1] = 0;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (ph == 0) && !rd[0] && !wr[0] && !rd[1] && !wr[1]
                   && !l2_pend && (l2_hold == 0) && !l2_resp;
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        logic [LW-1:0] wb_saved;
        logic [LW-1:0] a5_line;
        a5_line = {16{8'hA5}};
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0;
            wd[p] = '0;
            exp_rd[p] = '0;
        end
        l2_rdata = '0;
        rst_n = 1'b0;
        clear_stim();
        tick();
        tick();
        rst_n = 1'b1;

        // Lone read on A, L2 answers three cycles after the access starts.
        fix_d = 3; fix_w = 1; fix_data_en = 1'b1; fix_data = a5_line;
        rd[0] = 1'b1; addr[0] = 16'h1230; wd[0] = rand_line();
        tick();
        chk("t1_l2_address", l2_address, 16'h1230);
        wait_quiet("t1_done", 20);
        chk("t1_resp_a_pulses", rcnt[0], 1);
        chk("t1_resp_b_pulses", rcnt[1], 0);
        chk("t1_rdata_a", rdata_a, a5_line);

        // Simultaneous read A / write B right after reset: A first.
        do_reset();
        fix_d = 1; fix_data_en = 1'b0;
        rd[0] = 1'b1; addr[0] = rand_addr(); wd[0] = rand_line();
        wr[1] = 1'b1; addr[1] = rand_addr(); wb_saved = rand_line(); wd[1] = wb_saved;
        wait_quiet("t2_done", 30);
        chk("t2_grants", order.size(), 2);
        if (order.size() >= 2) begin
            chk("t2_first", order[0], 0);
            chk("t2_second", order[1], 1);
        end
        chk("t2_l2_wdata", l2_wdata, wb_saved);

        // Both ports requesting back-to-back for ten transactions.
        do_reset();
        fix_d = -1; fix_w = -1;
        mode[0] = 1; mode[1] = 1;
        for (int i = 0; i < 400 && (rcnt[0] + rcnt[1]) < 10; i++) tick();
        mode[0] = 0; mode[1] = 0;
        chk("t3_resp_a_pulses", rcnt[0], 5);
        chk("t3_resp_b_pulses", rcnt[1], 5);
        chk("t3_grants", order.size(), 10);
        for (int i = 0; i < order.size() && i < 10; i++) chk("t3_alternate", order[i], i % 2);
        wait_quiet("t3_drain", 40);

        // Requester inputs scrambled during the access.
        do_reset();
        fix_d = 4; fix_w = 1; scramble = 1'b1;
        wr[0] = 1'b1; addr[0] = 16'h0BEE; wb_saved = rand_line(); wd[0] = wb_saved;
        wait_quiet("t4_done", 20);
        scramble = 1'b0;
        chk("t4_addr_latched", l2_address, 16'h0BEE);
        chk("t4_wdata_latched", l2_wdata, wb_saved);

        // Reset mid-access, then a normal B read.
        do_reset();
        fix_d = 10;
        rd[0] = 1'b1; addr[0] = rand_addr(); wd[0] = rand_line();
        tick();
        tick();
        chk("t5_in_access", l2_read, 1'b1);
        do_reset();
        chk("t5_busy", busy, 1'b0);
        chk("t5_l2_read", l2_read, 1'b0);
        chk("t5_l2_address", l2_address, '0);
        fix_d = 2;
        rd[1] = 1'b1; addr[1] = rand_addr(); wd[1] = rand_line();
        wait_quiet("t5_done", 20);
        chk("t5_resp_b_pulses", rcnt[1], 1);
        chk("t5_resp_a_pulses", rcnt[0], 0);

        // Wide L2 completion pulse is consumed once.
        do_reset();
        fix_d = 1; fix_w = 3;
        rd[1] = 1'b1; addr[1] = rand_addr(); wd[1] = rand_line();
        wait_quiet("t6_done", 20);
        tick();
        tick();
        chk("t6_resp_b_pulses", rcnt[1], 1);
        chk("t6_transactions", order.size(), 1);

        // Random traffic from both clients.
        do_reset();
        fix_d = -1; fix_w = -1; scramble = 1'b1;
        mode[0] = 2; mode[1] = 2;
        for (int i = 0; i < 600; i++) tick();
        mode[0] = 0; mode[1] = 0;
        wait_quiet("t7_drain", 60);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
